// File: rtl/adder_pkg.sv
// Shared types for the two-requester sign-magnitude adder arbiter.
// The optional overflow flag is enabled by defining ADDER_ARB_OVF_EN.
package adder_pkg;

    localparam int SIGN_BIT = 15;
    localparam int MAG_W    = 15;

    typedef logic [15:0] sm_word_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/sm_adder.sv
// Combinational sign-magnitude adder: 15-bit magnitude wrap, never emits -0.
// carry_o reports a carry out of the magnitude on equal-sign additions only.
module sm_adder
    import adder_pkg::*;
(
    input  sm_word_t a_i,
    input  sm_word_t b_i,
    output sm_word_t sum_o,
    output logic     carry_o
);

    logic [MAG_W-1:0] mag_a;
    logic [MAG_W-1:0] mag_b;
    logic [MAG_W-1:0] mag_r;
    logic [MAG_W:0]   add_full;
    logic             sgn_a;
    logic             sgn_b;
    logic             sgn_r;

    always_comb begin
        mag_a    = a_i[MAG_W-1:0];
        mag_b    = b_i[MAG_W-1:0];
        // A -0 operand behaves as +0 so it never steers the result sign.
        sgn_a    = a_i[SIGN_BIT] && (mag_a != '0);
        sgn_b    = b_i[SIGN_BIT] && (mag_b != '0);
        add_full = {1'b0, mag_a} + {1'b0, mag_b};
        mag_r    = '0;
        sgn_r    = 1'b0;
        carry_o  = 1'b0;
        if (sgn_a == sgn_b) begin
            mag_r   = add_full[MAG_W-1:0];
            sgn_r   = sgn_a;
            carry_o = add_full[MAG_W];
        end else if (mag_a >= mag_b) begin
            mag_r = mag_a - mag_b;
            sgn_r = sgn_a;
        end else begin
            mag_r = mag_b - mag_a;
            sgn_r = sgn_b;
        end
        sum_o = {sgn_r && (mag_r != '0), mag_r};
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude adder between two requesters.
// Accept -> COMPUTE -> HOLD; rsp_ovf exists only when ADDER_ARB_OVF_EN is defined.
module adder_arbiter
    import adder_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_sum,
    output logic        rsp_id
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic        rsp_ovf
`endif
);

    state_t   state_q;
    logic     ptr_q;
    sm_word_t op_a_q;
    sm_word_t op_b_q;
    logic     op_id_q;
    logic     rsp_valid_q;
    sm_word_t rsp_sum_q;
    logic     rsp_id_q;
    sm_word_t add_sum;
    logic     add_carry;
    logic     gnt;
    logic     accept;

    // Contention goes to the pointer; otherwise whichever requester is valid.
    assign gnt    = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    assign accept = (state_q == ST_IDLE) && (req0_valid || req1_valid);

    assign req0_ready = !reset && (state_q == ST_IDLE) && !gnt;
    assign req1_ready = !reset && (state_q == ST_IDLE) && gnt;

    sm_adder u_sm_adder (
        .a_i     (op_a_q),
        .b_i     (op_b_q),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

`ifdef ADDER_ARB_OVF_EN
    logic rsp_ovf_q;
    assign rsp_ovf = rsp_ovf_q;
`else
    logic unused_add_carry;
    assign unused_add_carry = add_carry;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= RR_INIT;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
            rsp_ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_a_q  <= gnt ? req1_a : req0_a;
                        op_b_q  <= gnt ? req1_b : req0_b;
                        op_id_q <= gnt;
                        ptr_q   <= ~gnt;
                        state_q <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    rsp_sum_q   <= add_sum;
                    rsp_id_q    <= op_id_q;
`ifdef ADDER_ARB_OVF_EN
                    rsp_ovf_q   <= add_carry;
`endif
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: drivers push expected results, a monitor pops on each response.
module tb_adder_arbiter;

    localparam bit RR = 1'b0;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_sum;
`ifdef ADDER_ARB_OVF_EN
    logic        rsp_ovf;
`endif

    adder_arbiter #(.RR_INIT(RR)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_id     (rsp_id)
`ifdef ADDER_ARB_OVF_EN
        ,
        .rsp_ovf    (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        logic        id;
        logic        ovf;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   model_ptr = RR;
    bit   rsp_rand = 1'b0;
    bit   rsp_hold_low = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic flag(string name);
        total++;
        bad++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Reference: treat operands as signed integers, add, then fold back to a 15-bit magnitude.
    function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic id);
        exp_t e;
        int   va, vb, r, mag;
        va = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
        vb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
        r = va + vb;
        mag = (r < 0) ? -r : r;
        e.ovf = 1'b0;
        if (mag > 32767) begin
            mag = mag - 32768;
            e.ovf = 1'b1;
        end
        e.sum = {(r < 0) && (mag != 0), 15'(mag)};
        e.id = id;
        e.acc_cyc = 0;
        return e;
    endfunction

    function automatic logic [15:0] rnd_word();
        case ($urandom_range(0, 3))
            0: return 16'($urandom);
            1: return {1'($urandom), 15'($urandom_range(0, 20))};
            2: return ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
            default: return {1'($urandom), 15'h7FF0 + 15'($urandom_range(0, 15))};
        endcase
    endfunction

    task automatic drive(bit id, logic v, logic [15:0] a, logic [15:0] b);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b;
        end
    endtask

    // Entered and left at posedge+1; holds the pair until accepted.
    task automatic send(bit id, logic [15:0] a, logic [15:0] b);
        exp_t e;
        int   n = 0;
        bit   done = 1'b0;
        drive(id, 1'b1, a, b);
        while (!done) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                if (req0_valid && req1_valid)
                    check("grant_order", 32'(id), 32'(model_ptr));
                model_ptr = !id;
                e = model(a, b, id);
                e.acc_cyc = cyc;
                sb_q.push_back(e);
                done = 1'b1;
            end else if (++n > 300) begin
                flag("accept_timeout");
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        drive(id, 1'b0, rnd_word(), rnd_word());
    endtask

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rsp_hold_low ? 1'b0 : (rsp_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
        end
    end

    // Monitor: stability while stalled, latency on rise, scoreboard pop on handshake.
    initial begin
        bit          pv = 1'b0;
        bit          phs = 1'b0;
        logic [15:0] ps = '0;
        logic        pid = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
                phs = 1'b0;
            end else begin
                if (pv && !phs) begin
                    check("rsp_valid_held", 32'(rsp_valid), 32'd1);
                    if (rsp_valid) begin
                        check("rsp_sum_stable", 32'(rsp_sum), 32'(ps));
                        check("rsp_id_stable", 32'(rsp_id), 32'(pid));
                    end
                end
                if (rsp_valid && !pv && sb_q.size() > 0)
                    check("latency", 32'(cyc - sb_q[0].acc_cyc), 32'd2);
                if (rsp_valid)
                    check("no_accept_in_hold", {30'd0, req0_ready, req1_ready}, 32'd0);
                if (rsp_valid && rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        flag("unexpected_response");
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                        check("rsp_id", 32'(rsp_id), 32'(e.id));
`ifdef ADDER_ARB_OVF_EN
                        check("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
`endif
                    end
                end
                pv = rsp_valid;
                phs = rsp_valid && rsp_ready;
                ps = rsp_sum;
                pid = rsp_id;
            end
        end
    end

    initial begin
        int  n;
        bit  seen;
        reset = 1'b1;
        drive(1'b0, 1'b1, 16'h1111, 16'h2222);
        drive(1'b1, 1'b1, 16'h3333, 16'h4444);
        #12;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
        drive(1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Contention from reset with a 5-cycle response stall on the first result.
        rsp_hold_low = 1'b1;
        fork
            begin send(1'b0, 16'h0001, 16'h0002); send(1'b0, 16'h0010, 16'h8004); end
            begin send(1'b1, 16'h0100, 16'h0200); send(1'b1, 16'h8020, 16'h8003); end
            begin
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = rsp_valid;
                end
                if (!seen) flag("stall_wait_timeout");
                for (int k = 0; k < 5; k++) begin
                    check("stall_valid", 32'(rsp_valid), 32'd1);
                    check("stall_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
                    @(negedge clk);
                end
                rsp_hold_low = 1'b0;
            end
        join

        // Directed arithmetic corners, one requester at a time.
        send(1'b0, 16'h0005, 16'h0003);
        send(1'b1, 16'h8007, 16'h0003);
        send(1'b0, 16'h0005, 16'h8005);
        send(1'b1, 16'h8000, 16'h8000);
        send(1'b0, 16'h7FFF, 16'h0001);
        send(1'b1, 16'hFFFF, 16'h8001);
        send(1'b0, 16'h8000, 16'h8009);

        // Randomised traffic with random backpressure.
        rsp_rand = 1'b1;
        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                send(1'b0, rnd_word(), rnd_word());
            end
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                send(1'b1, rnd_word(), rnd_word());
            end
        join
        rsp_rand = 1'b0;
        n = 0;
        while (sb_q.size() > 0 && n < 50) begin @(posedge clk); #1; n++; end
        if (sb_q.size() > 0) flag("drain_timeout");

        // Reset while holding a response: it is discarded and the pointer restarts.
        rsp_hold_low = 1'b1;
        send(1'b0, 16'h1234, 16'h0001);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        if (!seen) flag("hold_wait_timeout");
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("reset_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_hold_rsp_sum", 32'(rsp_sum), 32'd0);
        sb_q.delete();
        model_ptr = RR;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rsp_hold_low = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        fork
            send(1'b0, 16'h0002, 16'h0002);
            send(1'b1, 16'h8001, 16'h8001);
        join
        n = 0;
        while (sb_q.size() > 0 && n < 50) begin @(posedge clk); #1; n++; end
        if (sb_q.size() > 0) flag("final_drain_timeout");
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
